led_bar_ctrl: RTL and testbench

//   Drives the 18-LED red bar (LED_RED) for the audio visualizer.
//   - Accepts audio level samples on a valid/ready handshake.
//   - Converts each sample to a thermometer bar and adds a decaying peak-hold dot.
//   - In test mode, replaces the bar with a fill/sweep pattern for board bring-up.
//   - Sits between the level detector and the top-level LED pins, on the divided clk from clk_cct.

---
 rtl/led_bar_ctrl.sv | 167 ++++++++++++++++
 tb/tb_led_bar_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_bar_ctrl.sv
// LED bar controller: scales audio level samples to an 18-LED thermometer bar with a
// decaying peak-hold dot, plus a fill/sweep test pattern for board bring-up.
module led_bar_ctrl #(
  parameter int NUM_LEDS     = 18,
  parameter int LEVEL_W      = 16,
  parameter int HOLD_CYCLES  = 13_500_000,
  parameter int DECAY_CYCLES = 1_350_000,
  parameter int SWEEP_CYCLES = 2_700_000
) (
  input  logic                clk,
  input  logic                reset_bar,
  input  logic                test_en,
  input  logic                level_valid,
  input  logic [LEVEL_W-1:0]  level_data,
  output logic                level_ready,
  output logic [NUM_LEDS-1:0] LED_RED,
  output logic [4:0]          peak_idx
);

  localparam int PROD_W = LEVEL_W + 5;
  localparam int CNT_MAX = (HOLD_CYCLES > DECAY_CYCLES) ? HOLD_CYCLES : DECAY_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam int SWP_W = $clog2(SWEEP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);
  localparam logic [SWP_W-1:0] SWEEP_LAST = SWP_W'(SWEEP_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] PAT_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] PAT_FULL = {NUM_LEDS{1'b1}};

  typedef enum logic [0:0] {RUN = 1'b0, TEST = 1'b1} state_t;

  state_t              state_r, state_n;
  logic                level_ready_r, level_ready_n;
  logic                new_r, new_n;
  logic [4:0]          bar_n_r, bar_n_n;
  logic [4:0]          peak_r, peak_n;
  logic [CNT_W-1:0]    hold_cnt_r, hold_cnt_n;
  logic [SWP_W-1:0]    sweep_cnt_r, sweep_cnt_n;
  logic [NUM_LEDS-1:0] pattern_r, pattern_n;
  logic [NUM_LEDS-1:0] led_r, led_n;
  logic [4:0]          peak_idx_r, peak_idx_n;
  logic                accept_s;
  logic [PROD_W-1:0]   prod_s;

  function automatic logic [NUM_LEDS-1:0] therm(input logic [4:0] n);
    logic [NUM_LEDS-1:0] res;
    for (int i = 0; i < NUM_LEDS; i++) res[i] = (5'(i) < n);
    return res;
  endfunction

  // Single dot at position p-1; no dot when p is zero.
  function automatic logic [NUM_LEDS-1:0] dot(input logic [4:0] p);
    logic [NUM_LEDS-1:0] res;
    for (int i = 0; i < NUM_LEDS; i++) res[i] = (5'(i + 1) == p);
    return res;
  endfunction

  assign accept_s = level_valid & level_ready_r;
  assign prod_s   = PROD_W'(level_data) * PROD_W'(NUM_LEDS + 1);

  // Next-state, scaling, peak tracking and output pattern selection.
  always_comb begin
    state_n       = state_r;
    level_ready_n = level_ready_r;
    new_n         = new_r;
    bar_n_n       = bar_n_r;
    peak_n        = peak_r;
    hold_cnt_n    = hold_cnt_r;
    sweep_cnt_n   = sweep_cnt_r;
    pattern_n     = pattern_r;
    led_n         = led_r;
    peak_idx_n    = peak_idx_r;
    case (state_r)
      RUN: begin
        if (accept_s) begin
          bar_n_n = prod_s[PROD_W-1:LEVEL_W];
          new_n   = 1'b1;
        end else begin
          new_n   = 1'b0;
        end
        if (test_en) begin
          state_n       = TEST;
          level_ready_n = 1'b0;
          pattern_n     = PAT_ONE;
          sweep_cnt_n   = '0;
          led_n         = PAT_ONE;
          peak_idx_n    = 5'd0;
        end else begin
          level_ready_n = 1'b1;
          if (new_r && (bar_n_r >= peak_r)) begin
            peak_n     = bar_n_r;
            hold_cnt_n = HOLD_LOAD;
          end else if (hold_cnt_r != '0) begin
            hold_cnt_n = hold_cnt_r - CNT_W'(1);
          end else if (peak_r != 5'd0) begin
            peak_n     = peak_r - 5'd1;
            hold_cnt_n = DECAY_LOAD;
          end else begin
            hold_cnt_n = hold_cnt_r;
          end
          led_n      = therm(bar_n_r) | dot(peak_n);
          peak_idx_n = peak_n;
        end
      end
      TEST: begin
        peak_idx_n = 5'd0;
        if (!test_en) begin
          state_n       = RUN;
          level_ready_n = 1'b1;
          new_n         = 1'b0;
          bar_n_n       = 5'd0;
          peak_n        = 5'd0;
          hold_cnt_n    = '0;
          led_n         = '0;
        end else begin
          level_ready_n = 1'b0;
          if (sweep_cnt_r == SWEEP_LAST) begin
            sweep_cnt_n = '0;
            if (pattern_r == PAT_FULL) begin
              pattern_n = PAT_ONE;
            end else begin
              pattern_n = {pattern_r[NUM_LEDS-2:0], 1'b1};
            end
          end else begin
            sweep_cnt_n = sweep_cnt_r + SWP_W'(1);
          end
          led_n = pattern_n;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      state_r       <= RUN;
      level_ready_r <= 1'b0;
      new_r         <= 1'b0;
      bar_n_r       <= 5'd0;
      peak_r        <= 5'd0;
      hold_cnt_r    <= '0;
      sweep_cnt_r   <= '0;
      pattern_r     <= '0;
      led_r         <= '0;
      peak_idx_r    <= 5'd0;
    end else begin
      state_r       <= state_n;
      level_ready_r <= level_ready_n;
      new_r         <= new_n;
      bar_n_r       <= bar_n_n;
      peak_r        <= peak_n;
      hold_cnt_r    <= hold_cnt_n;
      sweep_cnt_r   <= sweep_cnt_n;
      pattern_r     <= pattern_n;
      led_r         <= led_n;
      peak_idx_r    <= peak_idx_n;
    end
  end

  assign level_ready = level_ready_r;
  assign LED_RED     = led_r;
  assign peak_idx    = peak_idx_r;

endmodule

// File: tb/tb_led_bar_ctrl.sv
// Directed testbench for led_bar_ctrl with short hold/decay/sweep timing and a
// scoreboard queue holding the expected bar for each accepted sample.
module tb_led_bar_ctrl;

  logic        clk;
  logic        reset_bar;
  logic        test_en;
  logic        level_valid;
  logic [15:0] level_data;
  logic        level_ready;
  logic [17:0] LED_RED;
  logic [4:0]  peak_idx;

  typedef struct {
    int led;
    int pk;
  } exp_t;

  exp_t sb[$];
  logic [15:0] bd[$];
  int          bp[$];
  int vectors = 0;
  int miscompares = 0;

  led_bar_ctrl #(
    .NUM_LEDS(18), .LEVEL_W(16), .HOLD_CYCLES(4), .DECAY_CYCLES(2), .SWEEP_CYCLES(3)
  ) dut (
    .clk(clk), .reset_bar(reset_bar), .test_en(test_en),
    .level_valid(level_valid), .level_data(level_data),
    .level_ready(level_ready), .LED_RED(LED_RED), .peak_idx(peak_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_led(input logic [15:0] d, input int pk);
    int bar;
    bar = (int'(d) * 19) >>> 16;
    return ((1 << bar) - 1) | ((pk > 0) ? (1 << (pk - 1)) : 0);
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_led"}, int'(LED_RED), e.led);
      chk({tag, "_pidx"}, int'(peak_idx), e.pk);
    end
  endtask

  // Back-to-back samples from bd/bp; each shows on the LEDs one edge after acceptance.
  task automatic burst(input string tag);
    exp_t e;
    for (int i = 0; i < bd.size(); i++) begin
      level_valid = 1'b1;
      level_data  = bd[i];
      step();
      if (i > 0) pop_check(tag);
      e.led = exp_led(bd[i], bp[i]);
      e.pk  = bp[i];
      sb.push_back(e);
    end
    level_valid = 1'b0;
    step();
    pop_check(tag);
    bd.delete();
    bp.delete();
  endtask

  task automatic do_reset();
    reset_bar = 1'b0;
    step();
    reset_bar = 1'b1;
    step();
  endtask

  initial begin
    int pk;
    int len;
    reset_bar   = 1'b0;
    test_en     = 1'b0;
    level_valid = 1'b0;
    level_data  = 16'h0000;

    // T1: reset held for 3 edges, then released
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_rst_led", int'(LED_RED), 0);
      chk("t1_rst_ready", int'(level_ready), 0);
      chk("t1_rst_pidx", int'(peak_idx), 0);
    end
    reset_bar = 1'b1;
    step();
    chk("t1_ready", int'(level_ready), 1);
    chk("t1_led", int'(LED_RED), 0);

    // T2: full-scale sample
    bd.push_back(16'hFFFF); bp.push_back(18);
    burst("t2");

    // T3: peak holds 4 edges then drops every 2 edges; bar stays full
    for (int k = 2; k <= 9; k++) begin
      step();
      pk = (k <= 4) ? 18 : 18 - (k - 3) / 2;
      chk($sformatf("t3_pidx_k%0d", k), int'(peak_idx), pk);
      chk($sformatf("t3_led_k%0d", k), int'(LED_RED), 32'h3FFFF);
    end

    // T4: full-scale then half-scale then zero; peak dot stays at bit17
    do_reset();
    bd.push_back(16'hFFFF); bp.push_back(18);
    bd.push_back(16'h8000); bp.push_back(18);
    bd.push_back(16'h0000); bp.push_back(18);
    burst("t4");

    // Scaling floor boundary between bar 0 and bar 1
    do_reset();
    bd.push_back(16'h0D79); bp.push_back(0);
    bd.push_back(16'h0D7A); bp.push_back(1);
    burst("bnd");

    // T5: test sweep for 60 edges, samples offered but ignored
    test_en = 1'b1;
    step();
    chk("t5_entry_led", int'(LED_RED), 1);
    chk("t5_entry_ready", int'(level_ready), 0);
    level_valid = 1'b1;
    level_data  = 16'hFFFF;
    for (int i = 1; i < 60; i++) begin
      step();
      len = ((i / 3) % 18) + 1;
      chk($sformatf("t5_led_%0d", i), int'(LED_RED), (1 << len) - 1);
      chk($sformatf("t5_ready_%0d", i), int'(level_ready), 0);
      chk($sformatf("t5_pidx_%0d", i), int'(peak_idx), 0);
    end
    test_en     = 1'b0;
    level_valid = 1'b0;
    step();
    chk("t5_exit_led", int'(LED_RED), 0);
    chk("t5_exit_ready", int'(level_ready), 1);
    step();
    chk("t5_after_led", int'(LED_RED), 0);
    chk("t5_after_pidx", int'(peak_idx), 0);

    // T6: sample coincident with reset assertion is discarded
    bd.push_back(16'h8000); bp.push_back(9);
    burst("t6_pre");
    level_valid = 1'b1;
    level_data  = 16'hFFFF;
    reset_bar   = 1'b0;
    step();
    chk("t6_rst_led", int'(LED_RED), 0);
    chk("t6_rst_pidx", int'(peak_idx), 0);
    chk("t6_rst_ready", int'(level_ready), 0);
    level_valid = 1'b0;
    reset_bar   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_led_%0d", i), int'(LED_RED), 0);
      chk($sformatf("t6_pidx_%0d", i), int'(peak_idx), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
